// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
//   Memory-stage load unit placed directly in front of the data cache.
//   It accepts one load from execute per handshake and issues a word-aligned
//   request to the cache. It waits for the returned word, then extracts and
//   extends the byte, halfword or word. The result is offered to writeback
//   with valid/ready backpressure.
//   Misaligned loads and unsupported funct3 encodings never reach the cache.
//   Instead they raise a one-cycle exception pulse carrying the byte address.
//
// Ports
//   i_aclk, i_areset          clock, synchronous active-high reset
//   i_valid/o_ready           execute handshake; i_addr, i_funct3, i_rd payload
//   o_req/o_addr              word-aligned cache request, held until i_dvalid
//   i_dvalid/i_data           cache return
//   o_valid/i_ready           writeback handshake; o_rd, o_wdata payload
//   o_exc/o_exc_addr          illegal-load pulse and offending byte address
//
// DATA_SIZE mirrors the multicore_pkg data width (32).
// -----------------------------------------------------------------------------
module load_unit #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                 i_aclk,
  input  logic                 i_areset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [2:0]           i_funct3,
  input  logic [4:0]           i_rd,
  output logic                 o_req,
  output logic [ADDR_SIZE-1:0] o_addr,
  input  logic                 i_dvalid,
  input  logic [DATA_SIZE-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [4:0]           o_rd,
  output logic [DATA_SIZE-1:0] o_wdata,
  output logic                 o_exc,
  output logic [ADDR_SIZE-1:0] o_exc_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_t      state_r;
  logic [1:0]  offset_r;   // byte offset within the word of the pending load
  logic [2:0]  funct3_r;   // load type of the pending load
  logic        illegal_s;

  // Unsupported encodings and any access not naturally aligned are illegal.
  function automatic logic load_illegal(input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic bad;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = offset[0];
      F3_LW:         bad = (offset != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [DATA_SIZE-1:0] load_extract(input logic [2:0]           funct3,
                                                        input logic [1:0]           offset,
                                                        input logic [DATA_SIZE-1:0] data);
    logic [7:0]           byte_v;
    logic [15:0]          half_v;
    logic [DATA_SIZE-1:0] result;
    case (offset)
      2'b00:   byte_v = data[7:0];
      2'b01:   byte_v = data[15:8];
      2'b10:   byte_v = data[23:16];
      2'b11:   byte_v = data[31:24];
      default: byte_v = 8'h00;
    endcase
    if (offset[1]) begin
      half_v = data[31:16];
    end else begin
      half_v = data[15:0];
    end
    case (funct3)
      F3_LB:   result = {{(DATA_SIZE-8){byte_v[7]}}, byte_v};
      F3_LBU:  result = {{(DATA_SIZE-8){1'b0}}, byte_v};
      F3_LH:   result = {{(DATA_SIZE-16){half_v[15]}}, half_v};
      F3_LHU:  result = {{(DATA_SIZE-16){1'b0}}, half_v};
      F3_LW:   result = data;
      default: result = {DATA_SIZE{1'b0}};
    endcase
    return result;
  endfunction

  assign illegal_s = load_illegal(i_funct3, i_addr[1:0]);

  // Execute may only hand over a load while the unit is idle.
  assign o_ready = (state_r == IDLE);

  // Load sequencing FSM with all outputs registered.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state_r    <= IDLE;
      offset_r   <= 2'b00;
      funct3_r   <= 3'b000;
      o_req      <= 1'b0;
      o_addr     <= {ADDR_SIZE{1'b0}};
      o_valid    <= 1'b0;
      o_wdata    <= {DATA_SIZE{1'b0}};
      o_rd       <= 5'd0;
      o_exc      <= 1'b0;
      o_exc_addr <= {ADDR_SIZE{1'b0}};
    end else begin
      // The exception is a single-cycle pulse unless re-armed below.
      o_exc <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            if (illegal_s) begin
              o_exc      <= 1'b1;
              o_exc_addr <= i_addr;
            end else begin
              offset_r <= i_addr[1:0];
              funct3_r <= i_funct3;
              o_rd     <= i_rd;
              o_req    <= 1'b1;
              o_addr   <= {i_addr[ADDR_SIZE-1:2], 2'b00};
              state_r  <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_dvalid) begin
            o_req   <= 1'b0;
            o_wdata <= load_extract(funct3_r, offset_r, i_data);
            o_valid <= 1'b1;
            state_r <= HOLD;
          end
        end
        HOLD: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          o_req   <= 1'b0;
          o_valid <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
module tb_load_unit;

  logic        clk;
  logic        areset;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd;
  logic        o_req;
  logic [31:0] o_addr;
  logic        i_dvalid;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [4:0]  o_rd;
  logic [31:0] o_wdata;
  logic        o_exc;
  logic [31:0] o_exc_addr;

  int checks = 0;
  int errors = 0;

  load_unit #(.ADDR_SIZE(32), .DATA_SIZE(32)) dut (
    .i_aclk     (clk),
    .i_areset   (areset),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_addr     (i_addr),
    .i_funct3   (i_funct3),
    .i_rd       (i_rd),
    .o_req      (o_req),
    .o_addr     (o_addr),
    .i_dvalid   (i_dvalid),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_rd       (o_rd),
    .o_wdata    (o_wdata),
    .o_exc      (o_exc),
    .o_exc_addr (o_exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_illegal(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> (a[1:0] * 8);
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd4:    return {24'h0, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd5:    return {16'h0, sh[15:0]};
      default: return d;
    endcase
  endfunction

  // Full legal load: accept, lat WAIT cycles, then hold_lo cycles of i_ready low.
  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] d, input int lat, input int hold_lo,
                         input logic [31:0] exp);
    chk("accept_ready", o_ready, 1);
    i_valid = 1'b1; i_addr = a; i_funct3 = f3; i_rd = rd;
    tick();
    i_valid = 1'b0; i_addr = 32'hFFFF_FFFF; i_funct3 = 3'd2; i_rd = 5'd0;
    for (int i = 1; i <= lat; i++) begin
      chk("wait_req", o_req, 1);
      chk("wait_addr", o_addr, {a[31:2], 2'b00});
      chk("wait_ready", o_ready, 0);
      chk("wait_valid", o_valid, 0);
      if (i == lat) begin
        i_dvalid = 1'b1; i_data = d;
      end
      tick();
      i_dvalid = 1'b0; i_data = 32'h5A5A_5A5A;
    end
    for (int i = 0; i <= hold_lo; i++) begin
      chk("hold_req", o_req, 0);
      chk("hold_valid", o_valid, 1);
      chk("hold_wdata", o_wdata, exp);
      chk("hold_rd", o_rd, rd);
      chk("hold_ready", o_ready, 0);
      i_ready = (i == hold_lo);
      tick();
    end
    i_ready = 1'b0;
    chk("done_valid", o_valid, 0);
    chk("done_ready", o_ready, 1);
  endtask

  task automatic do_illegal(input logic [31:0] a, input logic [2:0] f3);
    i_valid = 1'b1; i_addr = a; i_funct3 = f3; i_rd = 5'd9;
    tick();
    i_valid = 1'b0;
    chk("exc_pulse", o_exc, 1);
    chk("exc_addr", o_exc_addr, a);
    chk("exc_req", o_req, 0);
    chk("exc_ready", o_ready, 1);
    tick();
    chk("exc_clear", o_exc, 0);
    chk("exc_req2", o_req, 0);
  endtask

  initial begin
    logic [31:0] ra, rd32;
    logic [2:0]  rf;
    areset = 1'b1; i_valid = 1'b0; i_addr = 32'h0; i_funct3 = 3'd0; i_rd = 5'd0;
    i_dvalid = 1'b0; i_data = 32'h0; i_ready = 1'b0;
    tick(); tick();
    areset = 1'b0;
    chk("rst_ready", o_ready, 1);
    chk("rst_req", o_req, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_exc", o_exc, 0);
    chk("rst_exc_addr", o_exc_addr, 0);

    // Byte/half/word extraction vectors.
    do_load(32'h0000_1003, 3'd0, 5'd5,  32'h80FF_1234, 1, 0, 32'hFFFF_FF80);
    do_load(32'h0000_1003, 3'd4, 5'd6,  32'h80FF_1234, 2, 1, 32'h0000_0080);
    do_load(32'h0000_1000, 3'd0, 5'd7,  32'h80FF_1234, 1, 0, 32'h0000_0034);
    do_load(32'h0000_1001, 3'd0, 5'd8,  32'h80FF_1234, 1, 0, 32'h0000_0012);
    do_load(32'h0000_1002, 3'd0, 5'd9,  32'h80FF_1234, 1, 0, 32'hFFFF_FFFF);
    do_load(32'h0000_2002, 3'd1, 5'd10, 32'h8001_7FFF, 1, 0, 32'hFFFF_8001);
    do_load(32'h0000_2002, 3'd5, 5'd11, 32'h8001_7FFF, 1, 0, 32'h0000_8001);
    do_load(32'h0000_2000, 3'd5, 5'd12, 32'h8001_7FFF, 1, 0, 32'h0000_7FFF);
    do_load(32'h0000_2000, 3'd1, 5'd13, 32'h1234_8765, 1, 0, 32'hFFFF_8765);
    do_load(32'h0000_3000, 3'd2, 5'd31, 32'hDEAD_BEEF, 5, 3, 32'hDEAD_BEEF);

    // Back-to-back illegal loads: two consecutive pulses.
    i_valid = 1'b1; i_addr = 32'h0000_1001; i_funct3 = 3'd2;
    tick();
    chk("b2b_exc1", o_exc, 1);
    chk("b2b_addr1", o_exc_addr, 32'h0000_1001);
    chk("b2b_req1", o_req, 0);
    chk("b2b_ready1", o_ready, 1);
    i_addr = 32'h0000_1000; i_funct3 = 3'd3;
    tick();
    i_valid = 1'b0;
    chk("b2b_exc2", o_exc, 1);
    chk("b2b_addr2", o_exc_addr, 32'h0000_1000);
    chk("b2b_req2", o_req, 0);
    tick();
    chk("b2b_exc_end", o_exc, 0);
    do_illegal(32'h0000_1000, 3'd6);
    do_illegal(32'h0000_1000, 3'd7);
    do_illegal(32'h0000_2001, 3'd1);
    do_illegal(32'h0000_2003, 3'd5);
    do_illegal(32'h0000_1002, 3'd2);

    // Reset in the second WAIT cycle; late i_dvalid ignored.
    i_valid = 1'b1; i_addr = 32'h0000_4000; i_funct3 = 3'd2; i_rd = 5'd3;
    tick();
    i_valid = 1'b0;
    chk("rw_req1", o_req, 1);
    tick();
    chk("rw_req2", o_req, 1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("rw_req_off", o_req, 0);
    chk("rw_addr_rst", o_addr, 0);
    chk("rw_rd_rst", o_rd, 0);
    chk("rw_ready", o_ready, 1);
    i_dvalid = 1'b1; i_data = 32'h1111_2222;
    tick();
    i_dvalid = 1'b0;
    chk("rw_late_dvalid", o_valid, 0);
    chk("rw_late_req", o_req, 0);
    do_load(32'h0000_4004, 3'd2, 5'd4, 32'hCAFE_F00D, 1, 0, 32'hCAFE_F00D);

    // Reset in HOLD discards the result; reset beats i_dvalid at the same edge.
    i_valid = 1'b1; i_addr = 32'h0000_5000; i_funct3 = 3'd2; i_rd = 5'd2;
    tick();
    i_valid = 1'b0; i_dvalid = 1'b1; i_data = 32'h7777_8888;
    tick();
    i_dvalid = 1'b0;
    chk("rh_valid", o_valid, 1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("rh_valid_rst", o_valid, 0);
    chk("rh_wdata_rst", o_wdata, 0);
    chk("rh_ready", o_ready, 1);
    i_valid = 1'b1; i_addr = 32'h0000_6000; i_funct3 = 3'd2; i_rd = 5'd1;
    tick();
    i_valid = 1'b0; i_dvalid = 1'b1; i_data = 32'h9999_AAAA; areset = 1'b1;
    tick();
    i_dvalid = 1'b0; areset = 1'b0;
    chk("rd_valid", o_valid, 0);
    chk("rd_req", o_req, 0);
    chk("rd_ready", o_ready, 1);

    // Random stream of legal/illegal loads with random latency and backpressure.
    for (int n = 0; n < 1000; n++) begin
      rf   = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rd32 = $urandom;
      if (is_illegal(rf, ra)) begin
        do_illegal(ra, rf);
      end else begin
        do_load(ra, rf, 5'($urandom_range(0, 31)), rd32, $urandom_range(1, 8),
                $urandom_range(0, 3), ref_ext(rf, ra, rd32));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_unit.md
# load_unit

Memory-access-stage load unit that sits directly upstream of the data cache. Accepts one load per handshake from execute, issues a word-aligned request to the data cache, and waits for the returned word. It then extracts and sign/zero-extends the byte, halfword or word and presents the result to writeback with valid/ready backpressure. Misaligned or unsupported loads are flagged as exceptions and never reach the cache.

## Interface
Parameters:
- ADDR_SIZE, 32, width of load address and cache address.
- DATA_SIZE, from multicore_pkg (32), width of cache data word and writeback data.

Ports:
- i_aclk  in  1  system clock; single clock domain.
- i_areset  in  1  reset; synchronous, active-high.
- i_valid  in  1  execute presents a load.
- o_ready  out  1  unit can accept a load this cycle.
- i_addr  in  ADDR_SIZE  byte address of the load.
- i_funct3  in  3  RV32I load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_rd  in  5  destination register tag.
- o_req  out  1  request to data cache.
- o_addr  out  ADDR_SIZE  word-aligned cache address: bits [1:0] = 0.
- i_dvalid  in  1  data cache returns data.
- i_data  in  DATA_SIZE  word returned by the cache.
- o_valid  out  1  load result available to writeback.
- i_ready  in  1  writeback accepts the result.
- o_rd  out  5  destination tag of the result.
- o_wdata  out  DATA_SIZE  extended load result.
- o_exc  out  1  one-cycle pulse: load address misaligned or funct3 illegal.
- o_exc_addr  out  ADDR_SIZE  offending byte address; valid while o_exc = 1.

## Operation
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - o_ready = 1.
  - Accept occurs when i_valid && o_ready; the unit registers i_addr, i_funct3 and i_rd.
  - Legal accepted load -> WAIT.
  - Illegal accepted load -> o_exc = 1 and o_exc_addr = i_addr on the next cycle; state stays IDLE.
- Illegal load is any of:
  - funct3 in {011, 110, 111}.
  - LH/LHU with addr[0] = 1.
  - LW with addr[1:0] != 0.
- WAIT:
  - o_req = 1; o_addr = {addr[ADDR_SIZE-1:2], 2'b00}.
  - o_req and o_addr are held stable until i_dvalid.
  - On i_dvalid: capture the extracted result and go to HOLD.
- Extraction is little-endian:
  - byte = i_data[8*addr[1:0] +: 8].
  - half = i_data[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes i_data unchanged.
- HOLD:
  - o_valid = 1; o_wdata and o_rd are held stable.
  - On i_ready -> IDLE.
- o_ready is high only in IDLE, so no new load is accepted in the cycle the HOLD handshake completes.
- i_dvalid is ignored outside WAIT.
- Reset values:
  - state = IDLE, o_ready = 1 (combinational from state).
  - o_req = 0, o_addr = 0, o_valid = 0, o_wdata = 0, o_rd = 0.
  - o_exc = 0, o_exc_addr = 0.

## Timing
- Accept at edge N -> o_req = 1 during cycle N+1.
- i_dvalid sampled at edge M -> o_req = 0 and o_valid = 1 during cycle M+1.
- Minimum accept-to-o_valid latency is 2 cycles (i_dvalid in the first WAIT cycle).
- o_valid may not drop until i_ready is sampled high.
- Illegal load accepted at edge N -> o_exc = 1 for exactly cycle N+1; o_req never asserts for it.
- Two back-to-back illegal loads produce two consecutive o_exc pulses.
- Reset at any edge, including mid-WAIT or mid-HOLD:
  - All outputs return to their reset values at that edge.
  - A pending result is discarded.
  - A late i_dvalid after reset is ignored.
- If i_dvalid and i_areset are high at the same edge, reset wins.

## Test plan
- LB 0x0000_1003, cache returns 0x80FF_1234 -> o_wdata 0xFFFF_FF80. LBU at the same address -> 0x0000_0080. In both cases o_addr = 0x0000_1000 and o_rd matches i_rd.
- LH 0x0000_2002 with 0x8001_7FFF -> 0xFFFF_8001. LHU -> 0x0000_8001. LHU 0x0000_2000 -> 0x0000_7FFF.
- LW 0x0000_1001 and funct3 = 011 at 0x0000_1000:
  - o_exc pulses exactly one cycle each, with o_exc_addr = 0x0000_1001 and 0x0000_1000 respectively.
  - o_req stays 0 throughout; o_ready stays 1.
- LW 0x0000_3000, i_dvalid after 5 cycles with 0xDEAD_BEEF, i_ready low for 3 cycles:
  - o_req high exactly 5 cycles with o_addr stable.
  - o_valid/o_wdata = 0xDEAD_BEEF held 4 cycles.
  - o_ready low from accept through HOLD completion.
- Reset in the second WAIT cycle:
  - o_req = 0 the next cycle.
  - A subsequent i_dvalid produces no o_valid.
  - A new load is accepted in the cycle after reset deasserts.
- Random stream of 1000 legal/illegal loads with random cache latency (1-8 cycles) and random i_ready:
  - Every result matches the reference extraction, in order.
  - Every illegal load yields exactly one o_exc and no cache request.
